mult32_seq: RTL and testbench
=============================

# mult32_seq

Iterative 32x32 multiplier for MULT/MULTU, producing the 64-bit HI/LO product in the execute stage. It is the direct consumer of the 4-bit group-PG adder slice: eight slices plus a lookahead carry unit form the 32-bit adder that the multiplier reuses every cycle. One partial product is accumulated per cycle using radix-2 shift-add, with a start/busy/done handshake to the pipeline stall logic.

## Interface
- No parameters; width fixed at 32 (constants in shared header).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sgn  in  1  1 = signed MULT, 0 = MULTU; sampled with start
- a  in  32  multiplicand, sampled with start
- b  in  32  multiplier, sampled with start
- busy  out  1  high in RUN, FIX_LO, FIX_HI
- done  out  1  one-cycle pulse when hi/lo become valid
- hi  out  32  product[63:32], held until next accepted start
- lo  out  32  product[31:0], held until next accepted start

## Operation
- States: IDLE, RUN, FIX_LO, FIX_HI, DONE.
- IDLE: on start=1, latch mcand=|a|, mplier=|b| (magnitudes only if sgn=1 and signed support compiled in, else raw), neg = sgn & (a[31]^b[31]); clear hi, lo, count=0; go RUN.
- Magnitude of 0x80000000 is 0x80000000 as unsigned; no overflow case.
- RUN, each cycle: sum = hi + (mplier[0] ? mcand : 0) through 32-bit CLA, carry out c; {hi,lo,mplier} shifted right 1 with c into hi[31], sum[0] into lo[31]. count increments; after 32nd cycle go FIX_LO if neg, else DONE.
- FIX_LO: lo = ~lo + 1 via adder (cin=1); carry saved. FIX_HI: hi = ~hi + saved carry. Go DONE.
- DONE: done=1 for exactly one cycle; return IDLE. hi/lo hold.
- start while busy or in DONE: ignored, no queuing.
- Adder outputs PG/GG of each slice feed the lookahead unit; no ripple across slices.

## Timing
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, count=0, neg=0.
- start accepted at edge t: busy=1 from t+1; unsigned or non-negative result: done=1 and hi/lo valid at t+33.
- Negative signed result: done at t+35.
- start may be reasserted in the cycle after done (IDLE); back-to-back throughput 34 cycles unsigned.
- rst mid-operation: next edge returns all reset values; partial product discarded, no done pulse.
- rst and start same cycle: rst wins.
- CLA path is the critical path: one 32-bit add per cycle, no multicycle constraint.

## Configuration
- MULT32_SIGNED_EN defined: sgn honoured, magnitude conversion and FIX_LO/FIX_HI states present.
- Undefined: sgn ignored, all operations unsigned, neg forced 0, FIX states and input negation logic removed; latency always 33.

## Structure
- Shared header: data width (32), count width (6), state encodings, product width (64).
- One sub-module: add32_cla: eight 4-bit PG slices plus two-level lookahead carry unit; ports a, b, cin, s, cout. Used for both accumulate and negation steps.
- Controller, shift register, and count stay in mult32_seq.

## Test plan
- Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, sgn=0 -> done at t+33, hi=0xFFFFFFFE, lo=0x00000001.
- Signed: a=0xFFFFFFFF (-1), b=1, sgn=1 -> done at t+35, hi=0xFFFFFFFF, lo=0xFFFFFFFF; same operands with sgn=0 -> hi=0, lo=0xFFFFFFFF at t+33.
- Signed edge: a=b=0x80000000, sgn=1 -> hi=0x40000000, lo=0; a=0x80000000, b=1, sgn=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Handshake: start held high through operation -> exactly one accepted op, single done pulse, next op accepted the cycle after done; start pulsed during RUN -> ignored.
- Reset mid-op: rst at RUN cycle 10 -> next edge busy=0, hi=lo=0, no done pulse; new start completes normally.
- Random: 1000 random a, b, sgn -> {hi,lo} equals behavioural 64-bit product, done latency matches rule.

Source files
------------

// File: rtl/mult32_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult32_seq_pkg
// Description : Shared constants for the iterative 32x32 multiplier: data,
//               count and product widths, FSM state encodings, and the 4-bit
//               carry-lookahead helpers used at every level of add32_cla.
// Revision    : 1.0 - initial release
// ============================================================================
package mult32_seq_pkg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 6;
  localparam int PROD_W  = 64;
  localparam int SLICE_W = 4;
  localparam int N_SLICE = DATA_W / SLICE_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_FIX_LO = 3'd2;
  localparam logic [2:0] ST_FIX_HI = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Carries into positions 0..3 of a 4-wide group, flattened sum-of-products
  // so that no carry depends on a neighbouring carry.
  function automatic logic [3:0] f_carry4(input logic [3:0] p,
                                          input logic [3:0] g,
                                          input logic       cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // Group {propagate, generate} of a 4-wide group.
  function automatic logic [1:0] f_grp_pg(input logic [3:0] p,
                                          input logic [3:0] g);
    logic gp;
    logic gg;
    gp = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gp, gg};
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult32_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mult32_seq_if
// Description : Request/response bundle between the pipeline stall logic
//               (master) and the multiplier (slave).
//               start/sgn/a/b : request, sampled by the multiplier in IDLE
//               busy/done     : status handshake
//               hi/lo         : 64-bit product, held until the next start
// Revision    : 1.0 - initial release
// ============================================================================
interface mult32_seq_if;
  import mult32_seq_pkg::*;

  logic              start;
  logic              sgn;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, sgn, a, b, input  busy, done, hi, lo);
  modport slave  (input  start, sgn, a, b, output busy, done, hi, lo);

endinterface
`default_nettype wire

// File: rtl/mult32_seq_add32_cla.sv
`default_nettype none
// ============================================================================
// Module      : add32_cla
// Description : 32-bit adder built from eight 4-bit PG slices and a two-level
//               lookahead carry unit (two 4-slice blocks, then a top merge).
//               a, b : addends     cin  : carry in
//               s    : sum         cout : carry out
// Revision    : 1.0 - initial release
// ============================================================================
module add32_cla
  import mult32_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] s,
  output logic              cout
);

  logic [DATA_W-1:0]  w_p;
  logic [DATA_W-1:0]  w_g;
  logic [N_SLICE-1:0] w_sp;   // per-slice group propagate
  logic [N_SLICE-1:0] w_sg;   // per-slice group generate
  logic [N_SLICE-1:0] w_sc;   // per-slice carry in, from the lookahead unit
  logic [1:0]         w_b0_pg;
  logic [1:0]         w_b1_pg;
  logic [3:0]         w_b0_c;
  logic [3:0]         w_b1_c;
  logic               w_c16;

  assign w_p = a ^ b;
  assign w_g = a & b;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLICE; gi++) begin : g_slice
      logic [SLICE_W-1:0] w_c;
      assign {w_sp[gi], w_sg[gi]}  = f_grp_pg(w_p[SLICE_W*gi +: SLICE_W], w_g[SLICE_W*gi +: SLICE_W]);
      assign w_c                   = f_carry4(w_p[SLICE_W*gi +: SLICE_W], w_g[SLICE_W*gi +: SLICE_W], w_sc[gi]);
      assign s[SLICE_W*gi +: SLICE_W] = w_p[SLICE_W*gi +: SLICE_W] ^ w_c;
    end
  endgenerate

  // Level 1: each block resolves the carries of its four slices from the
  // slice PG terms. Level 2: the upper block's carry in and the final carry
  // out come straight from block PG terms and cin.
  assign w_b0_pg = f_grp_pg(w_sp[3:0], w_sg[3:0]);
  assign w_b1_pg = f_grp_pg(w_sp[7:4], w_sg[7:4]);
  assign w_c16   = w_b0_pg[0] | (w_b0_pg[1] & cin);
  assign w_b0_c  = f_carry4(w_sp[3:0], w_sg[3:0], cin);
  assign w_b1_c  = f_carry4(w_sp[7:4], w_sg[7:4], w_c16);
  assign w_sc    = {w_b1_c, w_b0_c};
  assign cout    = w_b1_pg[0] | (w_b1_pg[1] & w_b0_pg[0]) | (w_b1_pg[1] & w_b0_pg[1] & cin);

endmodule
`default_nettype wire

// File: rtl/mult32_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult32_seq
// Description : Iterative radix-2 shift-add 32x32 multiplier (MULT/MULTU).
//               One partial product per cycle through add32_cla; the same
//               adder performs the final two's-complement of the product.
//               clk, rst : clock, synchronous active-high reset
//               mul_if   : start/sgn/a/b request, busy/done/hi/lo response
//               Build option MULT32_SIGNED_EN: honour sgn (magnitude
//               conversion plus FIX_LO/FIX_HI negation). Without it every
//               operation is unsigned and latency is always 33 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mult32_seq
  import mult32_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mult32_seq_if.slave mul_if
);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_neg;

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_neg_in;
  logic [DATA_W-1:0] w_add_a;
  logic [DATA_W-1:0] w_add_b;
  logic              w_add_cin;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;

`ifdef MULT32_SIGNED_EN
  logic r_carry;      // carry out of the low-word negation
  assign w_op_a   = mul_if.sgn ? f_abs(mul_if.a) : mul_if.a;
  assign w_op_b   = mul_if.sgn ? f_abs(mul_if.b) : mul_if.b;
  assign w_neg_in = mul_if.sgn & (mul_if.a[DATA_W-1] ^ mul_if.b[DATA_W-1]);
`else
  logic w_unused_cfg;
  assign w_op_a       = mul_if.a;
  assign w_op_b       = mul_if.b;
  assign w_neg_in     = 1'b0;
  assign w_unused_cfg = mul_if.sgn ^ r_neg;
`endif

  // Adder operand select: accumulate in RUN, negate in the FIX states.
  always_comb begin
    w_add_a   = r_hi;
    w_add_b   = r_mplier[0] ? r_mcand : '0;
    w_add_cin = 1'b0;
`ifdef MULT32_SIGNED_EN
    if (r_state == ST_FIX_LO) begin
      w_add_a   = ~r_lo;
      w_add_b   = '0;
      w_add_cin = 1'b1;
    end else if (r_state == ST_FIX_HI) begin
      w_add_a   = ~r_hi;
      w_add_b   = '0;
      w_add_cin = r_carry;
    end
`endif
  end

  add32_cla u_add (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .s    (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
`ifdef MULT32_SIGNED_EN
      r_carry  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mul_if.start) begin
            r_mcand  <= w_op_a;
            r_mplier <= w_op_b;
            r_neg    <= w_neg_in;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          // {hi,lo,mplier} >> 1 with the adder carry entering at the top;
          // the multiplier bits drain out as the product fills lo.
          r_hi     <= {w_cout, w_sum[DATA_W-1:1]};
          r_lo     <= {w_sum[0], r_lo[DATA_W-1:1]};
          r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
          r_count  <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(DATA_W-1)) begin
`ifdef MULT32_SIGNED_EN
            r_state <= r_neg ? ST_FIX_LO : ST_DONE;
`else
            r_state <= ST_DONE;
`endif
          end
        end
`ifdef MULT32_SIGNED_EN
        ST_FIX_LO: begin
          r_lo    <= w_sum;
          r_carry <= w_cout;
          r_state <= ST_FIX_HI;
        end
        ST_FIX_HI: begin
          r_hi    <= w_sum;
          r_state <= ST_DONE;
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mul_if.busy = (r_state == ST_RUN) || (r_state == ST_FIX_LO) || (r_state == ST_FIX_HI);
  assign mul_if.done = (r_state == ST_DONE);
  assign mul_if.hi   = r_hi;
  assign mul_if.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult32_seq
// Description : Self-checking bench for mult32_seq. A cycle-level behavioural
//               model (timer plus 64-bit arithmetic product) is compared with
//               busy/done/hi/lo every cycle; directed operations additionally
//               pin literal products and done latencies.
//               Follows MULT32_SIGNED_EN to pick the expected behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult32_seq;

`ifdef MULT32_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  mult32_seq_if bus ();

  always #5 clk = ~clk;

  mult32_seq u_dut (
    .clk    (clk),
    .rst    (rst),
    .mul_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] f_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (SIGNED_EN && s) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (SIGNED_EN && s) ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic int f_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    return (SIGNED_EN && s && (a[31] ^ b[31])) ? 35 : 33;
  endfunction

  // Behavioural model: m_k = cycle index since acceptance (0 = idle).
  int          m_k    = 0;
  int          m_lat  = 33;
  logic [63:0] m_exp  = '0;
  logic [63:0] m_hold = '0;
  bit          armed  = 1'b0;

  always @(posedge clk) begin
    armed <= 1'b1;
    if (rst) begin
      m_k    <= 0;
      m_hold <= '0;
    end else if (m_k == 0) begin
      if (bus.start) begin
        m_k   <= 1;
        m_exp <= f_prod(bus.a, bus.b, bus.sgn);
        m_lat <= f_lat(bus.a, bus.b, bus.sgn);
      end
    end else if (m_k == m_lat) begin
      m_k    <= 0;
      m_hold <= m_exp;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", {63'h0, bus.busy}, {63'h0, (m_k != 0) && (m_k != m_lat)});
      check("done", {63'h0, bus.done}, {63'h0, (m_k != 0) && (m_k == m_lat)});
      if (m_k == 0)
        check("held_product", {bus.hi, bus.lo}, m_hold);
      else if (m_k == m_lat)
        check("product", {bus.hi, bus.lo}, m_exp);
    end
  end

  // One operation from an idle negedge; optional extra start pulse at
  // cycle pulse_at while the operation is in flight.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eh, input logic [31:0] el, input int elat,
                        input string tag, input int pulse_at);
    int n;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sgn = s; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 60) begin
      if (pulse_at != 0 && n == pulse_at) begin
        bus.a = 32'd100; bus.b = 32'd100; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(elat));
    check({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, eh});
    check({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, el});
  endtask

  initial begin
    int c;
    int d1;
    int d2;
    int nd;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] rp;

    bus.start = 1'b0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'h0, bus.busy}, 64'h0);
    check("reset_done", {63'h0, bus.done}, 64'h0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    rst = 1'b0;

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33, "u_max", 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, SIGNED_EN ? 32'hFFFFFFFF : 32'h0,
           32'hFFFFFFFF, SIGNED_EN ? 35 : 33, "s_m1x1", 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 32'hFFFFFFFF, 33, "u_m1x1", 0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 33, "s_min_sq", 0);
    run_op(32'h80000000, 32'h00000001, 1'b1, SIGNED_EN ? 32'hFFFFFFFF : 32'h0,
           32'h80000000, SIGNED_EN ? 35 : 33, "s_min_x1", 0);
    run_op(32'hFFFFFFF9, 32'h00000006, 1'b1, SIGNED_EN ? 32'hFFFFFFFF : 32'h5,
           32'hFFFFFFD6, SIGNED_EN ? 35 : 33, "s_m7x6", 0);
    run_op(32'd3, 32'd5, 1'b0, 32'h0, 32'd15, 33, "u_3x5", 0);

    // Start pulse during RUN must be ignored.
    run_op(32'd7, 32'd9, 1'b0, 32'h0, 32'd63, 33, "ign_pulse", 10);

    // Start held high: next op is accepted in the idle cycle after done.
    @(negedge clk);
    bus.a = 32'd2; bus.b = 32'd3; bus.sgn = 1'b0; bus.start = 1'b1;
    c = 0; d1 = 0; d2 = 0;
    while (d2 == 0 && c < 120) begin
      @(negedge clk);
      c++;
      if (bus.done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
      if (d1 != 0 && c == d1 + 2) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("held_first_done", 64'(d1), 64'd33);
    check("held_gap", 64'(d2 - d1), 64'd34);

    // Reset in RUN cycle 10 discards the operation.
    @(negedge clk);
    bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.sgn = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("rst_mid_nodone", 64'(nd), 64'h0);
    run_op(32'd1000, 32'd1000, 1'b0, 32'h0, 32'd1000000, 33, "after_rst", 0);

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_start_hilo", {bus.hi, bus.lo}, 64'h0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rp = f_prod(ra, rb, rs);
      run_op(ra, rb, rs, rp[63:32], rp[31:0], f_lat(ra, rb, rs), "rand", 0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
